// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle
//  Description : Execute-stage ALU. Add/sub/logic/shift complete in one
//                cycle; MUL runs as a 32-step iterative shift-add multiplier
//                with busy/done handshaking. Result and zero flag are
//                registered and held until the next accepted start.
//  Options     : ALU_MUL_EARLY_TERM_EN - finish MUL as soon as the remaining
//                multiplier bits are all zero.
//  Op codes    : ADD=0x00 SUB=0x01 AND=0x02 OR=0x03 XOR=0x04 SLL=0x05
//                SRL=0x06 MUL=0x07 (ALU_OP_* values from arch_defines.v);
//                any other code yields result 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] alu_in0,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [4:0]       alu_op_select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);

    localparam logic [4:0] C_OP_ADD = 5'h00;
    localparam logic [4:0] C_OP_SUB = 5'h01;
    localparam logic [4:0] C_OP_AND = 5'h02;
    localparam logic [4:0] C_OP_OR  = 5'h03;
    localparam logic [4:0] C_OP_XOR = 5'h04;
    localparam logic [4:0] C_OP_SLL = 5'h05;
    localparam logic [4:0] C_OP_SRL = 5'h06;
    localparam logic [4:0] C_OP_MUL = 5'h07;

    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [WIDTH-1:0]  mcand_q,  mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q,   zero_d;

    logic [4:0]        w_shamt;
    logic [WIDTH-1:0]  w_single;
    logic [WIDTH-1:0]  w_acc_sum;

    // Single-cycle datapath, evaluated on the operands presented at accept
    always_comb begin
        w_shamt  = alu_in1[4:0];
        w_single = '0;
        case (alu_op_select)
            C_OP_ADD: w_single = alu_in0 + alu_in1;
            C_OP_SUB: w_single = alu_in0 - alu_in1;
            C_OP_AND: w_single = alu_in0 & alu_in1;
            C_OP_OR:  w_single = alu_in0 | alu_in1;
            C_OP_XOR: w_single = alu_in0 ^ alu_in1;
            C_OP_SLL: w_single = alu_in0 << w_shamt;
            C_OP_SRL: w_single = alu_in0 >> w_shamt;
            default:  w_single = '0;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set
    always_comb begin
        w_acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Sequencer next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (alu_op_select == C_OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = alu_in0;
                        mplier_d = alu_in1;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d = w_single;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
`ifdef ALU_MUL_EARLY_TERM_EN
                if (mplier_q == '0) begin
                    // No set bits remain, so the accumulator already holds the product
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
`else
                begin
`endif
                    acc_d    = w_acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_ITER) begin
                        result_d = w_acc_sum;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Start is deliberately not sampled here
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        zero_d = (result_d == '0);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy       = (state_q == S_MUL);
    assign done       = (state_q == S_DONE);
    assign alu_result = result_q;
    assign zero       = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_multicycle
//  Description : Self-checking directed bench for alu_multicycle using an
//                expected-result queue. Honours ALU_MUL_EARLY_TERM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_AND = 5'h02;
    localparam logic [4:0] OP_OR  = 5'h03;
    localparam logic [4:0] OP_XOR = 5'h04;
    localparam logic [4:0] OP_SLL = 5'h05;
    localparam logic [4:0] OP_SRL = 5'h06;
    localparam logic [4:0] OP_MUL = 5'h07;
    localparam logic [4:0] OP_BAD = 5'h1F;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [4:0]  alu_op_select;
    logic        busy;
    logic        done;
    logic [31:0] alu_result;
    logic        zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
        int          busy_n;
    } exp_t;

    exp_t sb[$];

    alu_multicycle #(.WIDTH(32), .CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .alu_in0       (alu_in0),
        .alu_in1       (alu_in1),
        .alu_op_select (alu_op_select),
        .busy          (busy),
        .done          (done),
        .alu_result    (alu_result),
        .zero          (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected MUL latency (cycles from the accept cycle to done)
    function automatic int mul_lat(input logic [31:0] b);
        int h;
`ifdef ALU_MUL_EARLY_TERM_EN
        h = -1;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
        if (h + 3 > 33) return 33;
        return h + 3;
`else
        h = 0;
        return 33 + h;
`endif
    endfunction

    // Issue one op at the current negedge and check it against the queue head
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit disturb);
        exp_t e;
        int   lat;
        int   busy_n;
        bit   got;
        e.res    = exp_res;
        e.z      = (exp_res == 32'd0);
        e.lat    = exp_lat;
        e.busy_n = exp_lat - 1;
        sb.push_back(e);
        alu_op_select = op;
        alu_in0       = a;
        alu_in1       = b;
        start         = 1'b1;
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = k;
            end else if (busy) begin
                busy_n++;
            end
            start = 1'b0;
            if (disturb && !got && k >= 3) begin
                start         = (k == 5);
                alu_in0       = $urandom;
                alu_in1       = $urandom;
                alu_op_select = OP_ADD;
            end
        end
        e = sb.pop_front();
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(e.busy_n));
        check({tag, " result"}, alu_result, e.res);
        check({tag, " zero"}, 32'(zero), 32'(e.z));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit seen_done;
        rst           = 1'b1;
        start         = 1'b0;
        alu_in0       = 32'd0;
        alu_in1       = 32'd0;
        alu_op_select = OP_ADD;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", alu_result, 32'd0);
        check("reset zero", 32'(zero), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 1'b0);
        run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 32'h0, 1, 1'b0);
        run_op("sub_wrap", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 1'b0);
        run_op("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1, 1'b0);
        run_op("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 1'b0);
        run_op("sll_mask", OP_SLL, 32'h1, 32'h21, 32'h2, 1, 1'b0);
        run_op("srl_31", OP_SRL, 32'h8000_0000, 32'd31, 32'h1, 1, 1'b0);
        run_op("mul_ffff", OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF,
               mul_lat(32'h0001_0001), 1'b1);
        run_op("mul_allones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
               mul_lat(32'hFFFF_FFFF), 1'b0);
        run_op("mul_7x0", OP_MUL, 32'd7, 32'd0, 32'd0, mul_lat(32'd0), 1'b0);
        run_op("mul_7x3", OP_MUL, 32'd7, 32'd3, 32'd21, mul_lat(32'd3), 1'b0);
        run_op("mul_signed", OP_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, mul_lat(32'd7), 1'b0);
        run_op("mul_big", OP_MUL, 32'd12345, 32'd6789, 32'd83810205, mul_lat(32'd6789), 1'b1);
        run_op("bad_op", OP_BAD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1, 1'b0);
        run_op("mul_pre_rst", OP_MUL, 32'd3, 32'd5, 32'd15, mul_lat(32'd5), 1'b0);

        // Reset in cycle T+10 of a MUL aborts it
        alu_op_select = OP_MUL;
        alu_in0       = 32'h0000_1234;
        alu_in1       = 32'h8000_FFFF;
        start         = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", alu_result, 32'd0);
        check("abort zero", 32'(zero), 32'd1);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort no_done", 32'(seen_done), 32'd0);
        run_op("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 1, 1'b0);

        // Start held through the DONE cycle: ignored there, accepted one cycle later
        alu_op_select = OP_ADD;
        alu_in0       = 32'd10;
        alu_in1       = 32'd20;
        start         = 1'b1;
        @(negedge clk);
        check("b2b first_done", 32'(done), 32'd1);
        check("b2b first_result", alu_result, 32'd30);
        alu_in0 = 32'd1;
        alu_in1 = 32'd1;
        @(negedge clk);
        check("b2b ignored_done", 32'(done), 32'd0);
        check("b2b held_result", alu_result, 32'd30);
        @(negedge clk);
        start = 1'b0;
        check("b2b second_done", 32'(done), 32'd1);
        check("b2b second_result", alu_result, 32'd2);
        @(negedge clk);
        check("b2b single_pulse", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
